rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Shares the single 96-bit RNG core between up to `NREQ` controllers (error-space generation, key generation, encryption sequencing) that each previously owned the `rng_start`/`rng_finish`/`rng_data` handshake. It accepts one-cycle request pulses, grants the RNG round-robin, and routes each 96-bit word back to its requester with a one-cycle completion pulse. An optional one-word prefetch buffer hides RNG latency for the next request.

## Interface
Parameters:
- `NREQ`, 3: number of requesters, 2..8.
- `RW`, 96: RNG word width.

Ports:
- `clk`  in  1: the only clock.
- `rst_b`  in  1: synchronous, active-high reset.
- `req_start`  in  NREQ: per-requester one-cycle request pulse.
- `req_finish`  out  NREQ: per-requester one-cycle completion pulse; at most one bit high.
- `req_data`  out  RW: shared word, valid only in the cycle `req_finish` is high.
- `rng_start`  out  1: one-cycle pulse to the RNG core.
- `rng_finish`  in  1: RNG completion pulse.
- `rng_data`  in  RW: RNG word, sampled when `rng_finish`=1.
- `prefetch_en`  in  1: allows the block to refill the buffer while idle.
- `busy`  out  1: high when any request is pending or an RNG request is outstanding.

## Operation
- `pending[NREQ-1:0]` register: bit i is set by `req_start[i]` and cleared when i is served. A `req_start[i]` while `pending[i]`=1 is ignored; requests do not queue per requester.
- Round-robin: the grant goes to the first pending index scanning from `last_grant+1` with wrap. `last_grant` resets to NREQ-1, so index 0 wins first.
- States:
  - IDLE, with `pending`≠0 and `buf_valid`=1: grant g, go to DELIVER with the data source set to the buffer.
  - IDLE, with `pending`≠0 and `buf_valid`=0: pulse `rng_start`, set `owner`=g, go to WAIT.
  - IDLE, with `pending`=0, `buf_valid`=0 and `prefetch_en`=1: pulse `rng_start`, set `owner`=BUF, go to WAIT.
  - WAIT, on `rng_finish`: if `owner`=BUF, load the buffer, set `buf_valid`=1 and go to IDLE. Otherwise latch `rng_data` into the output register and go to DELIVER.
  - DELIVER: assert `req_finish[g]` and drive `req_data`, clear `pending[g]`, update `last_grant`=g, clear `buf_valid` if the buffer was the source, then go to IDLE.
- A `req_start` arriving during a prefetch WAIT is served from the buffer after that fill completes.
- `rng_finish` outside WAIT is ignored; a stale completion after reset is dropped.
- `req_start[g]` in the same cycle as `req_finish[g]` sets `pending[g]` again, which counts as a new request.
- Clearing `prefetch_en` never discards a valid buffer or aborts an outstanding fill.

## Timing
- Reset values:
  - `req_finish`=0, `req_data`=0, `rng_start`=0, `busy`=0.
  - `pending`=0, `buf_valid`=0, state IDLE.
- All outputs are registered.
- Buffer-hit latency: `req_start` at cycle t produces `req_finish` at t+2. A concurrent refill `rng_start` goes out at t+3 when `prefetch_en`=1.
- Miss latency: `req_start` at t produces `rng_start` at t+1. With `rng_finish` at t+1+L, `req_finish` follows at t+2+L.
- At most one RNG request is outstanding at any time. `rng_start` is never high for two consecutive cycles.
- `busy` = (`pending`≠0) | (state≠IDLE), registered, so it is one cycle late relative to `req_start`.

## Structure
- Shared package `rollo_pkg` holds:
  - `RNG_W`=96;
  - the state enum {IDLE, WAIT, DELIVER};
  - the owner encoding, where BUF = NREQ.
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs (`pending`, `last_grant`) and outputs (`grant_idx`, `grant_vld`).

## Test plan
- Reset, then `req_start`=3'b001 with `prefetch_en`=0 and RNG latency 5 with data 96'hA5…: `rng_start` at t+1, `req_finish`=3'b001 at t+7, `req_data`=96'hA5….
- `req_start`=3'b111 in one cycle: served in order 0,1,2, with exactly three `rng_start` pulses and never two outstanding.
- `prefetch_en`=1 with idle requesters: one `rng_start` fills the buffer. Then `req_start[1]` gives `req_finish[1]` two cycles later with the buffered word, and a refill `rng_start` follows one cycle after that.
- Double `req_start[2]` while `pending[2]`=1: exactly one `req_finish[2]`.
- Assert `rst_b` during WAIT, then deliver `rng_finish`: no `req_finish`, `busy`=0, and the next request is served normally.
- After a grant to 2, pending 0 and 1 both set: 0 is served before 1 (wrap from `last_grant`=2).

Source files
------------

// File: rtl/rollo_pkg.sv
// Purpose: shared constants, FSM state type and owner encoding for the RNG arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rollo_pkg;

    localparam int RNG_W = 96;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2
    } arb_state_t;

    // Owner codes 0..nreq-1 name a requester; code nreq marks a buffer fill.
    function automatic int owner_buf(input int nreq);
        return nreq;
    endfunction

    function automatic int owner_w(input int nreq);
        return $clog2(nreq + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin priority encoder; picks first pending index after last_grant, with wrap.
// Latency: combinational.
// Backpressure: none; ports pending/last_grant in, grant_idx/grant_vld out.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        // Scan farthest-first so the nearest pending index after last_grant
        // overwrites any earlier match; last_grant itself has lowest priority.
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (pending[idx]) begin
                grant_idx = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Purpose: shares one RNG core among NREQ requesters, round-robin, with a one-word prefetch buffer.
// Latency: buffer hit req_start->req_finish 2 cycles; miss 2 cycles plus RNG latency.
// Backpressure: none; one pending request per requester, repeat pulses while pending are absorbed.
// Ports: req_start/req_finish/req_data to requesters, rng_start/rng_finish/rng_data to the RNG,
//        prefetch_en enables idle refills, busy flags pending work or a non-idle FSM.
module rng_arbiter
    import rollo_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int RW   = RNG_W
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [NREQ-1:0] req_start,
    output logic [NREQ-1:0] req_finish,
    output logic [RW-1:0]   req_data,
    output logic            rng_start,
    input  logic            rng_finish,
    input  logic [RW-1:0]   rng_data,
    input  logic            prefetch_en,
    output logic            busy
);

    localparam int            IW      = $clog2(NREQ);
    localparam int            OW      = owner_w(NREQ);
    localparam logic [OW-1:0] OWN_BUF = OW'(owner_buf(NREQ));

    arb_state_t      state, state_nxt;
    logic [NREQ-1:0] pending, pending_nxt;
    logic [IW-1:0]   last_grant, last_grant_nxt;
    logic [IW-1:0]   gnt, gnt_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic            buf_valid, buf_valid_nxt;
    logic [RW-1:0]   buf_data, buf_data_nxt;
    logic            src_buf, src_buf_nxt;
    logic [NREQ-1:0] req_finish_nxt;
    logic [RW-1:0]   req_data_nxt;
    logic            rng_start_nxt;
    logic            busy_nxt;

    logic [NREQ-1:0] pend_eff, pend_after;
    logic [NREQ-1:0] pick_pend;
    logic [IW-1:0]   pick_last;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    // Same-cycle requests count, so a miss can launch rng_start on the next edge.
    assign pend_eff   = pending | req_start;
    // Pending as it will be after the DELIVER cycle; a re-request of gnt survives.
    assign pend_after = (pending & ~(NREQ'(1) << gnt)) | req_start;

    // A buffer hit grants from registered pending only, which gives the
    // two-cycle hit latency. DELIVER looks ahead with the updated last_grant
    // so the next RNG request (or refill) issues without an idle cycle.
    always_comb begin
        pick_pend = buf_valid ? pending : pend_eff;
        pick_last = last_grant;
        if (state == DELIVER) begin
            pick_pend = pend_after;
            pick_last = gnt;
        end
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .pending    (pick_pend),
        .last_grant (pick_last),
        .grant_idx  (pick_idx),
        .grant_vld  (pick_vld)
    );

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pend_eff;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        owner_nxt      = owner;
        buf_valid_nxt  = buf_valid;
        buf_data_nxt   = buf_data;
        src_buf_nxt    = src_buf;
        req_finish_nxt = '0;
        req_data_nxt   = req_data;
        rng_start_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (buf_valid) begin
                    if (pick_vld) begin
                        gnt_nxt        = pick_idx;
                        src_buf_nxt    = 1'b1;
                        req_finish_nxt = NREQ'(1) << pick_idx;
                        req_data_nxt   = buf_data;
                        state_nxt      = DELIVER;
                    end
                end else if (pick_vld) begin
                    rng_start_nxt = 1'b1;
                    owner_nxt     = OW'(pick_idx);
                    state_nxt     = WAIT;
                end else if (prefetch_en) begin
                    rng_start_nxt = 1'b1;
                    owner_nxt     = OWN_BUF;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (rng_finish) begin
                    if (owner == OWN_BUF) begin
                        buf_data_nxt  = rng_data;
                        buf_valid_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        gnt_nxt        = IW'(owner);
                        src_buf_nxt    = 1'b0;
                        req_finish_nxt = NREQ'(1) << IW'(owner);
                        req_data_nxt   = rng_data;
                        state_nxt      = DELIVER;
                    end
                end
            end
            DELIVER: begin
                pending_nxt    = pend_after;
                last_grant_nxt = gnt;
                // The buffer is always empty once DELIVER ends: a hit consumed
                // it, and a miss only happens while it is empty.
                buf_valid_nxt  = 1'b0;
                state_nxt      = IDLE;
                if (pick_vld) begin
                    rng_start_nxt = 1'b1;
                    owner_nxt     = OW'(pick_idx);
                    state_nxt     = WAIT;
                end else if (prefetch_en) begin
                    rng_start_nxt = 1'b1;
                    owner_nxt     = OWN_BUF;
                    state_nxt     = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (pending_nxt != '0) || (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state      <= IDLE;
            pending    <= '0;
            last_grant <= IW'(NREQ - 1);
            gnt        <= '0;
            owner      <= '0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            src_buf    <= 1'b0;
            req_finish <= '0;
            req_data   <= '0;
            rng_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            last_grant <= last_grant_nxt;
            gnt        <= gnt_nxt;
            owner      <= owner_nxt;
            buf_valid  <= buf_valid_nxt;
            buf_data   <= buf_data_nxt;
            src_buf    <= src_buf_nxt;
            req_finish <= req_finish_nxt;
            req_data   <= req_data_nxt;
            rng_start  <= rng_start_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Purpose: self-checking bench for rng_arbiter with a behavioural RNG responder and word/pending model.
// Latency: checks exact hit/miss/refill cycles in directed tasks, invariants on every cycle.
// Backpressure: responder enforces a single outstanding RNG request.
module tb_rng_arbiter;

    localparam int NREQ       = 3;
    localparam int RW         = 96;
    localparam int STARVE_MAX = 80;

    logic            clk         = 1'b0;
    logic            rst_b       = 1'b1;
    logic [NREQ-1:0] req_start   = '0;
    logic [NREQ-1:0] req_finish;
    logic [RW-1:0]   req_data;
    logic            rng_start;
    logic            rng_finish  = 1'b0;
    logic [RW-1:0]   rng_data    = '0;
    logic            prefetch_en = 1'b0;
    logic            busy;

    rng_arbiter #(.NREQ(NREQ), .RW(RW)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_start   (req_start),
        .req_finish  (req_finish),
        .req_data    (req_data),
        .rng_start   (rng_start),
        .rng_finish  (rng_finish),
        .rng_data    (rng_data),
        .prefetch_en (prefetch_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // RNG responder state
    int            rng_lat     = 3;
    bit            use_fixed   = 1'b0;
    logic [RW-1:0] fixed_word  = '0;
    bit            outstanding = 1'b0;
    int            cnt         = 0;
    int            n_rng_start = 0;
    logic          prev_rs     = 1'b0;
    int            rs_cyc_q[$];

    // Reference model: words leave the RNG and reach requesters in order.
    logic [RW-1:0]   words_q[$];
    logic [NREQ-1:0] mdl_pend = '0;
    int              req_cyc[NREQ];

    typedef struct {
        int            idx;
        int            cyc;
        logic [RW-1:0] data;
    } fin_t;
    fin_t fin_q[$];

    always @(negedge clk) begin
        rng_finish = 1'b0;
        if (outstanding) begin
            cnt--;
            if (cnt <= 0) begin
                rng_finish  = 1'b1;
                rng_data    = use_fixed ? fixed_word : {$urandom, $urandom, $urandom};
                words_q.push_back(rng_data);
                outstanding = 1'b0;
            end
        end
        if (rng_start === 1'b1) begin
            vectors++;
            n_rng_start++;
            rs_cyc_q.push_back(cyc);
            if (outstanding || prev_rs === 1'b1) begin
                miscompares++;
                $display("FAIL rng_single_outstanding: cyc=%0d outstanding=%0b prev_rng_start=%0b, required 0/0",
                         cyc, outstanding, prev_rs);
            end
            outstanding = 1'b1;
            cnt         = rng_lat;
        end
        prev_rs = rng_start;
    end

    task automatic observe();
        int idx;
        logic [RW-1:0] exp;
        if (mdl_pend != '0) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_pending: cyc=%0d busy=%b, required 1", cyc, busy);
            end
        end
        if (rng_start === 1'b1) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_wait: cyc=%0d busy=%b, required 1", cyc, busy);
            end
        end
        if (req_finish !== '0) begin
            vectors++;
            if ($countones(req_finish) != 1) begin
                miscompares++;
                $display("FAIL finish_onehot: cyc=%0d req_finish=%b, required one bit", cyc, req_finish);
            end else begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_finish[i]) idx = i;
                vectors++;
                if (!mdl_pend[idx]) begin
                    miscompares++;
                    $display("FAIL finish_spurious: cyc=%0d idx=%0d not pending", cyc, idx);
                end else if (cyc - req_cyc[idx] > STARVE_MAX) begin
                    miscompares++;
                    $display("FAIL starvation: idx=%0d waited %0d, required <= %0d", idx, cyc - req_cyc[idx], STARVE_MAX);
                end
                mdl_pend[idx] = 1'b0;
                vectors++;
                if (words_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL finish_no_word: cyc=%0d idx=%0d, no RNG word available", cyc, idx);
                end else begin
                    exp = words_q.pop_front();
                    if (req_data !== exp) begin
                        miscompares++;
                        $display("FAIL req_data: cyc=%0d got %h, required %h", cyc, req_data, exp);
                    end
                end
                fin_q.push_back('{idx, cyc, req_data});
            end
        end
    endtask

    task automatic step(input logic [NREQ-1:0] rs);
        req_start = rs;
        for (int i = 0; i < NREQ; i++) if (rs[i] && !mdl_pend[i]) req_cyc[i] = cyc;
        mdl_pend |= rs;
        @(negedge clk);
        req_start = '0;
        observe();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy === 1'b0 && mdl_pend == '0 && !outstanding) && n < budget) begin
            step('0);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL idle_timeout: busy=%b pending=%b outstanding=%0b after %0d cycles",
                     busy, mdl_pend, outstanding, n);
        end
    endtask

    task automatic do_reset();
        prefetch_en = 1'b0;
        mdl_pend    = '0;
        rst_b       = 1'b1;
        repeat (3) step('0);
        rst_b = 1'b0;
        words_q.delete();
        fin_q.delete();
        rs_cyc_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 4;
        if (req_finish !== '0) begin miscompares++; $display("FAIL rst_req_finish: %b, required 0", req_finish); end
        if (req_data !== '0) begin miscompares++; $display("FAIL rst_req_data: %h, required 0", req_data); end
        if (rng_start !== 1'b0) begin miscompares++; $display("FAIL rst_rng_start: %b, required 0", rng_start); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: %b, required 0", busy); end
        repeat (5) step('0);
        vectors++;
        if (rs_cyc_q.size() != 0) begin
            miscompares++;
            $display("FAIL idle_no_start: %0d rng_start pulses, required 0", rs_cyc_q.size());
        end
    endtask

    task automatic test_miss_latency();
        int t;
        do_reset();
        use_fixed  = 1'b1;
        fixed_word = {12{8'hA5}};
        rng_lat    = 5;
        t = cyc;
        step(3'b001);
        wait_idle(50);
        use_fixed = 1'b0;
        vectors += 2;
        if (rs_cyc_q.size() != 1 || rs_cyc_q[0] != t + 1) begin
            miscompares++;
            $display("FAIL miss_rng_start: %0d pulses first at %0d, required 1 at %0d",
                     rs_cyc_q.size(), rs_cyc_q.size() ? rs_cyc_q[0] - t : -1, 1);
        end
        if (fin_q.size() != 1 || fin_q[0].idx != 0 || fin_q[0].cyc != t + 7 || fin_q[0].data !== {12{8'hA5}}) begin
            miscompares++;
            $display("FAIL miss_finish: %0d finishes idx=%0d at t+%0d data=%h, required 1 idx=0 at t+7 data A5..",
                     fin_q.size(), fin_q.size() ? fin_q[0].idx : -1, fin_q.size() ? fin_q[0].cyc - t : -1,
                     fin_q.size() ? fin_q[0].data : '0);
        end
    endtask

    task automatic test_burst();
        do_reset();
        rng_lat = 2;
        step(3'b111);
        wait_idle(100);
        vectors++;
        if (fin_q.size() != 3 || rs_cyc_q.size() != 3) begin
            miscompares++;
            $display("FAIL burst_count: %0d finishes %0d rng_start, required 3 and 3", fin_q.size(), rs_cyc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (fin_q[i].idx != i) begin
                    miscompares++;
                    $display("FAIL burst_order: slot %0d got idx %0d, required %0d", i, fin_q[i].idx, i);
                end
            end
        end
    endtask

    task automatic test_prefetch_hit();
        int t;
        do_reset();
        rng_lat     = 3;
        prefetch_en = 1'b1;
        repeat (10) step('0);
        vectors++;
        if (rs_cyc_q.size() != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL prefetch_fill: %0d rng_start busy=%b, required 1 and 0", rs_cyc_q.size(), busy);
        end
        t = cyc;
        step(3'b010);
        step('0);
        step('0);
        step(3'b100);
        repeat (5) step('0);
        vectors += 3;
        if (rs_cyc_q.size() != 2 || rs_cyc_q[1] != t + 3) begin
            miscompares++;
            $display("FAIL prefetch_refill: %0d pulses last at t+%0d, required 2 with last at t+3",
                     rs_cyc_q.size(), rs_cyc_q[rs_cyc_q.size()-1] - t);
        end
        if (fin_q.size() < 1 || fin_q[0].idx != 1 || fin_q[0].cyc != t + 2) begin
            miscompares++;
            $display("FAIL prefetch_hit: idx=%0d at t+%0d, required idx=1 at t+2",
                     fin_q.size() ? fin_q[0].idx : -1, fin_q.size() ? fin_q[0].cyc - t : -1);
        end
        if (fin_q.size() != 2 || fin_q[1].idx != 2 || fin_q[1].cyc != t + 8) begin
            miscompares++;
            $display("FAIL prefetch_after_fill: %0d finishes, second idx=%0d at t+%0d, required idx=2 at t+8",
                     fin_q.size(), fin_q.size() > 1 ? fin_q[1].idx : -1, fin_q.size() > 1 ? fin_q[1].cyc - t : -1);
        end
        prefetch_en = 1'b0;
        wait_idle(50);
    endtask

    task automatic test_double_req();
        do_reset();
        rng_lat = 4;
        step(3'b100);
        step(3'b100);
        step(3'b100);
        wait_idle(50);
        vectors++;
        if (fin_q.size() != 1 || fin_q[0].idx != 2 || rs_cyc_q.size() != 1) begin
            miscompares++;
            $display("FAIL double_req: %0d finishes %0d rng_start, required 1 finish[2] and 1 start",
                     fin_q.size(), rs_cyc_q.size());
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        do_reset();
        rng_lat = 6;
        step(3'b001);
        step('0);
        mdl_pend = '0;
        rst_b    = 1'b1;
        step('0);
        step('0);
        rst_b = 1'b0;
        n = 0;
        while (outstanding && n < 20) begin step('0); n++; end
        step('0);
        step('0);
        vectors += 2;
        if (fin_q.size() != 0) begin
            miscompares++;
            $display("FAIL stale_finish: %0d req_finish after reset, required 0", fin_q.size());
        end
        if (busy !== 1'b0 || outstanding) begin
            miscompares++;
            $display("FAIL stale_busy: busy=%b outstanding=%0b, required 0/0", busy, outstanding);
        end
        words_q.delete();
        rng_lat = 2;
        step(3'b010);
        wait_idle(50);
        vectors++;
        if (fin_q.size() != 1 || fin_q[0].idx != 1) begin
            miscompares++;
            $display("FAIL after_reset_req: %0d finishes, required 1 finish[1]", fin_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rng_lat = 2;
        step(3'b100);
        wait_idle(50);
        step(3'b011);
        wait_idle(50);
        vectors++;
        if (fin_q.size() != 3 || fin_q[1].idx != 0 || fin_q[2].idx != 1) begin
            miscompares++;
            $display("FAIL wrap_from_2: %0d finishes, order %0d,%0d, required 0 then 1",
                     fin_q.size(), fin_q.size() > 1 ? fin_q[1].idx : -1, fin_q.size() > 2 ? fin_q[2].idx : -1);
        end
        fin_q.delete();
        step(3'b010);
        wait_idle(50);
        step(3'b101);
        wait_idle(50);
        vectors++;
        if (fin_q.size() != 3 || fin_q[1].idx != 2 || fin_q[2].idx != 0) begin
            miscompares++;
            $display("FAIL wrap_from_1: %0d finishes, order %0d,%0d, required 2 then 0",
                     fin_q.size(), fin_q.size() > 1 ? fin_q[1].idx : -1, fin_q.size() > 2 ? fin_q[2].idx : -1);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rs;
        int n_req = 0;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 49) == 0) prefetch_en = ~prefetch_en;
            rng_lat = $urandom_range(1, 6);
            for (int b = 0; b < NREQ; b++) rs[b] = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < NREQ; b++) if (rs[b] && !mdl_pend[b]) n_req++;
            step(rs);
        end
        prefetch_en = 1'b0;
        wait_idle(200);
        vectors++;
        if (fin_q.size() != n_req) begin
            miscompares++;
            $display("FAIL random_served: %0d finishes, required %0d", fin_q.size(), n_req);
        end
    endtask

    initial begin
        test_reset();
        test_miss_latency();
        test_burst();
        test_prefetch_hit();
        test_double_req();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
